mealy_seq_detector: RTL and testbench

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

---
 rtl/mealy_seq_detector.sv | 105 ++++++++++
 tb/tb_mealy_seq_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - Mealy serial pattern detector with saturating match counter
module mealy_seq_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           OVERLAP = 1,
    parameter int           CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 a,
    input  logic                 clear,
    output logic                 y,
    output logic [$clog2(N)-1:0] prefix,
    output logic [CNT_W-1:0]     count,
    output logic                 sat
);

    localparam int PW    = $clog2(N);
    localparam int DEPTH = 1 << PW;
    localparam logic [PW-1:0]    LAST    = PW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Longest pattern prefix (capped at N-1) that ends the stream "prefix of
    // length s, then bit b". On a completed match this yields the longest
    // proper border, which is exactly the overlapping restart point.
    function automatic int prefix_after(input int s, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic tb;
        best = 0;
        if (s < N) begin
            for (int k = 1; k <= N - 1; k++) begin
                if (k <= s + 1) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        idx = s + 1 - k + j;
                        tb  = (idx == s) ? b : PATTERN[N-1-idx];
                        if (PATTERN[N-1-j] != tb) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
            end
        end
        return best;
    endfunction

    // Transition tables fixed at elaboration; unreachable rows (s >= N) go to 0.
    logic [PW-1:0] nxt0 [DEPTH];
    logic [PW-1:0] nxt1 [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        localparam int NX0 = prefix_after(g, 1'b0);
        localparam int NX1 = prefix_after(g, 1'b1);
        assign nxt0[g] = PW'(NX0);
        assign nxt1[g] = PW'(NX1);
    end

    logic [PW-1:0]    state;
    logic [PW-1:0]    state_nxt;
    logic [PW-1:0]    fwd;
    logic             hit;
    logic [CNT_W-1:0] count_nxt;

    // Match flag and next prefix length; a completed match restarts at the
    // border (overlapping) or at zero (non-overlapping).
    always_comb begin
        fwd       = a ? nxt1[state] : nxt0[state];
        hit       = (state == LAST) && (a == PATTERN[0]);
        y         = en && !reset && hit;
        state_nxt = state;
        if (en) begin
            if (hit && (OVERLAP == 0)) state_nxt = '0;
            else                       state_nxt = fwd;
        end
    end

    // Saturating counter update; clear wins over increment but still counts a same-cycle match.
    always_comb begin
        count_nxt = count;
        if (clear)                        count_nxt = y ? CNT_W'(1) : '0;
        else if (y && count != CNT_MAX)   count_nxt = count + CNT_W'(1);
    end

    // Prefix-length register.
    always_ff @(posedge clk) begin
        if (reset) state <= '0;
        else       state <= state_nxt;
    end

    // Match counter and its registered saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_nxt;
            sat   <= (count_nxt == CNT_MAX);
        end
    end

    assign prefix = state;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb/tb_mealy_seq_detector.sv - randomized and directed bench for mealy_seq_detector
module tb_mealy_seq_detector;

    localparam int N = 4;
    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic reset, en, a, clear;
    logic y0, y1, y2;
    logic [1:0] p0, p1, p2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic s0, s1, s2;

    int n_tests = 0;
    int n_fail  = 0;

    bit q0[$];
    bit q1[$];
    int m0, m1, m2;
    bit ey0, ey1;

    always #5 clk = ~clk;

    mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d0 (
        .clk(clk), .reset(reset), .en(en), .a(a), .clear(clear),
        .y(y0), .prefix(p0), .count(c0), .sat(s0));
    mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d1 (
        .clk(clk), .reset(reset), .en(en), .a(a), .clear(clear),
        .y(y1), .prefix(p1), .count(c1), .sat(s1));
    mealy_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) d2 (
        .clk(clk), .reset(reset), .en(en), .a(a), .clear(clear),
        .y(y2), .prefix(p2), .count(c2), .sat(s2));

    // Longest k < N such that the last k stream bits equal the first k pattern bits.
    function automatic int longest(input bit h[$]);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if (h.size() >= k) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (h[h.size() - k + j] != PAT[N-1-j]) ok = 1'b0;
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // True when the stream h followed by b ends with the full pattern.
    function automatic bit completes(input bit h[$], input bit b);
        bit hh[$];
        hh = h;
        hh.push_back(b);
        if (hh.size() < N) return 1'b0;
        for (int j = 0; j < N; j++)
            if (hh[hh.size() - N + j] != PAT[N-1-j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input bit r, input bit e, input bit b, input bit c);
        reset = r; en = e; a = b; clear = c;
        ey0 = !r && e && completes(q0, b);
        ey1 = !r && e && completes(q1, b);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            q0.delete(); q1.delete();
            m0 = 0; m1 = 0; m2 = 0;
        end else begin
            if (en) begin
                q0.push_back(a);
                if (q0.size() > N - 1) void'(q0.pop_front());
                if (ey1) q1.delete();
                else begin
                    q1.push_back(a);
                    if (q1.size() > N - 1) void'(q1.pop_front());
                end
            end
            if (clear) begin
                m0 = ey0 ? 1 : 0; m1 = ey1 ? 1 : 0; m2 = ey0 ? 1 : 0;
            end else begin
                if (ey0 && m0 < 255) m0++;
                if (ey1 && m1 < 255) m1++;
                if (ey0 && m2 < 3)   m2++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++; if (y0 !== 1'b0) begin n_fail++; $display("FAIL reset_y got %b exp 0", y0); end
        tick();
        n_tests++; if (p0 !== 2'd0) begin n_fail++; $display("FAIL reset_prefix got %0d exp 0", p0); end
        n_tests++; if (c0 !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", c0); end
        n_tests++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", s0); end
        n_tests++; if (c2 !== 2'd0 || s2 !== 1'b0) begin n_fail++; $display("FAIL reset_cnt2 got %0d/%b exp 0/0", c2, s2); end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1011;
        logic [3:0] yexp = 4'b0001;
        logic [7:0] pexp = {2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, bits[3-i], 1'b0);
            n_tests++; if (y0 !== yexp[3-i]) begin n_fail++; $display("FAIL basic_y bit%0d got %b exp %b", i, y0, yexp[3-i]); end
            tick();
            n_tests++; if (p0 !== pexp[7-2*i -: 2]) begin n_fail++; $display("FAIL basic_prefix bit%0d got %0d exp %0d", i, p0, pexp[7-2*i -: 2]); end
        end
        n_tests++; if (c0 !== 8'd1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", c0); end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] yo   = 7'b0001001;
        logic [6:0] yn   = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, bits[6-i], 1'b0);
            n_tests++; if (y0 !== yo[6-i]) begin n_fail++; $display("FAIL overlap_y bit%0d got %b exp %b", i, y0, yo[6-i]); end
            n_tests++; if (y1 !== yn[6-i]) begin n_fail++; $display("FAIL nonoverlap_y bit%0d got %b exp %b", i, y1, yn[6-i]); end
            tick();
        end
        n_tests++; if (c0 !== 8'd2) begin n_fail++; $display("FAIL overlap_count got %0d exp 2", c0); end
        n_tests++; if (c1 !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_count got %0d exp 1", c1); end
    endtask

    task automatic test_enable_gap();
        logic [2:0] tail = 3'b011;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, bit'($urandom % 2), 1'b0);
            n_tests++; if (y0 !== 1'b0) begin n_fail++; $display("FAIL gap_y cyc%0d got %b exp 0", i, y0); end
            tick();
            n_tests++; if (p0 !== 2'd1) begin n_fail++; $display("FAIL gap_prefix cyc%0d got %0d exp 1", i, p0); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, tail[2-i], 1'b0);
            n_tests++; if (y0 !== (i == 2)) begin n_fail++; $display("FAIL gap_tail_y bit%0d got %b exp %b", i, y0, (i == 2)); end
            tick();
        end
    endtask

    task automatic test_saturate();
        logic [12:0] bits = 13'b1011011011011;
        int k = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b1, bits[12-i], 1'b0);
            tick();
            if (i % 3 == 0 && i > 0) begin
                k++;
                n_tests++; if (int'(c2) !== ((k < 3) ? k : 3)) begin n_fail++; $display("FAIL sat_count match%0d got %0d exp %0d", k, c2, (k < 3) ? k : 3); end
                n_tests++; if (s2 !== (k >= 3)) begin n_fail++; $display("FAIL sat_flag match%0d got %b exp %b", k, s2, (k >= 3)); end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++; if (c2 !== 2'd0 || s2 !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0d/%b exp 0/0", c2, s2); end
        n_tests++; if (p2 !== 2'd1) begin n_fail++; $display("FAIL sat_clear_prefix got %0d exp 1", p2); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] head = 3'b101;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, head[2-i], 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++; if (y0 !== 1'b0) begin n_fail++; $display("FAIL midreset_y got %b exp 0", y0); end
        tick();
        n_tests++; if (p0 !== 2'd0) begin n_fail++; $display("FAIL midreset_prefix got %0d exp 0", p0); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            n_tests++; if (y0 !== 1'b0) begin n_fail++; $display("FAIL midreset_tail_y bit%0d got %b exp 0", i, y0); end
            tick();
            n_tests++; if (p0 !== 2'd1) begin n_fail++; $display("FAIL midreset_tail_prefix bit%0d got %0d exp 1", i, p0); end
        end
    endtask

    task automatic test_clear_match();
        logic [15:0] bits = 16'b1011011011011011;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, bits[15-i], 1'b0);
            tick();
        end
        n_tests++; if (c0 !== 8'd5) begin n_fail++; $display("FAIL clrmatch_pre_count got %0d exp 5", c0); end
        drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        n_tests++; if (y0 !== 1'b1) begin n_fail++; $display("FAIL clrmatch_y got %b exp 1", y0); end
        tick();
        n_tests++; if (c0 !== 8'd1) begin n_fail++; $display("FAIL clrmatch_count got %0d exp 1", c0); end
        n_tests++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL clrmatch_sat got %b exp 0", s0); end
    endtask

    task automatic test_random();
        bit r, e, b, c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 60) == 0;
            e = ($urandom % 4) != 0;
            b = bit'($urandom % 2);
            c = ($urandom % 40) == 0;
            drive(r, e, b, c);
            n_tests++; if (y0 !== ey0 || y1 !== ey1 || y2 !== ey0) begin n_fail++; $display("FAIL rand_y cyc%0d got %b%b%b exp %b%b%b", i, y0, y1, y2, ey0, ey1, ey0); end
            tick();
            n_tests++; if (int'(p0) !== longest(q0) || int'(p1) !== longest(q1) || int'(p2) !== longest(q0)) begin
                n_fail++; $display("FAIL rand_prefix cyc%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, p0, p1, p2, longest(q0), longest(q1), longest(q0)); end
            n_tests++; if (int'(c0) !== m0 || int'(c1) !== m1 || int'(c2) !== m2) begin
                n_fail++; $display("FAIL rand_count cyc%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, c0, c1, c2, m0, m1, m2); end
            n_tests++; if (s0 !== (m0 == 255) || s1 !== (m1 == 255) || s2 !== (m2 == 3)) begin
                n_fail++; $display("FAIL rand_sat cyc%0d got %b%b%b exp %b%b%b", i, s0, s1, s2, (m0 == 255), (m1 == 255), (m2 == 3)); end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; a = 1'b0; clear = 1'b0;
        m0 = 0; m1 = 0; m2 = 0;
        tick();
        test_reset();
        test_basic();
        test_overlap();
        test_enable_gap();
        test_saturate();
        test_reset_mid();
        test_clear_match();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
